instr_prefetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the decode stage, replacing the direct instruction-memory read in the fetch stage. It runs its own fetch PC and issues word requests to instruction memory over a request/grant/response handshake, tolerating variable memory latency. Returned words are buffered with their PCs in a small FIFO. Decode consumes them through a valid/ready handshake, and a redirect from the branch unit flushes the queue and restarts fetch.

---
 rtl/instr_prefetch_queue.sv | 134 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: runs its own fetch PC over a req/gnt/rvalid memory
// handshake and buffers {instr, pc} pairs for decode; a redirect flushes and restarts fetch.
module instr_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  req_pc_q, req_pc_d;
   logic [CNT_W-1:0] count_q, count_d, count_after;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      hold_instr_q, hold_instr_d;
   logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
   logic [31:0]      fifo_instr [DEPTH];
   logic [XLEN-1:0]  fifo_pc    [DEPTH];
   logic             push, pop, space;
   logic [XLEN-1:0]  redirect_pc_al;

   assign redirect_pc_al = redirect_pc & ~XLEN'(3);
   assign if_valid       = (count_q != '0);
   assign pop            = if_valid && if_ready && !redirect;
   assign push           = (state_q == S_WAIT) && imem_rvalid && !redirect;
   assign space          = (count_after < CNT_W'(DEPTH));

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = fetch_pc_q;
   // No fall-through: an empty queue keeps presenting the last head it had.
   assign if_instr  = if_valid ? fifo_instr[rd_ptr_q] : hold_instr_q;
   assign if_pc     = if_valid ? fifo_pc[rd_ptr_q]    : hold_pc_q;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      count_after = count_q;
      if (push && !pop)
         count_after = count_q + CNT_W'(1);
      else if (pop && !push)
         count_after = count_q - CNT_W'(1);
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      unique case (state_q)
         S_IDLE: begin
            if (!redirect && space)
               state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_gnt) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + XLEN'(4);
               state_d    = redirect ? S_DISCARD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid)
               state_d = (!redirect && space) ? S_REQ : S_IDLE;
            else if (redirect)
               state_d = S_DISCARD;
         end
         S_DISCARD: begin
            if (imem_rvalid)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Redirect wins over the increment of a grant in the same cycle.
      if (redirect)
         fetch_pc_d = redirect_pc_al;
   end

   always_comb begin
      count_d      = redirect ? '0 : count_after;
      rd_ptr_d     = redirect ? '0 : rd_ptr_q + PTR_W'(pop);
      wr_ptr_d     = redirect ? '0 : wr_ptr_q + PTR_W'(push);
      hold_instr_d = if_valid ? fifo_instr[rd_ptr_q] : hold_instr_q;
      hold_pc_d    = if_valid ? fifo_pc[rd_ptr_q]    : hold_pc_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= RESET_PC;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   // NOTE: the storage array is not reset; an entry is only read after a push has written it.
   always_ff @(negedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr_q] <= imem_rdata;
         fifo_pc[wr_ptr_q]    <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: a memory model answers requests, directed
// tests push expected {pc, instr} pairs, and a monitor compares every decode pop.
module tb_instr_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   instr_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   pop_cycles[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   pop_count = 0;
   int   gnt_count = 0;
   int   cycle = 0;
   int   lat = 1;
   bit   gnt_en = 1'b1;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, instr: word_of(pc)});
   endtask

   // Memory model: grants when enabled, answers exactly once, lat cycles after the grant.
   initial begin : mem_model
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 1'b0;
      cnt = 0;
      paddr = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         imem_gnt = 1'b0;
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata = word_of(paddr);
                  pend = 1'b0;
               end else begin
                  cnt--;
               end
            end
            if (imem_req && gnt_en && !pend && !imem_rvalid) begin
               imem_gnt = 1'b1;
               pend = 1'b1;
               cnt = lat - 1;
               paddr = imem_addr;
               gnt_count++;
            end
         end
      end
   end

   // Monitor: compares the head against the scoreboard on every accepted pop.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         cycle++;
         #2;
         if (rst_n && if_valid && if_ready && !redirect) begin
            pop_count++;
            pop_cycles.push_back(cycle);
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("pop_pc", if_pc, e.pc);
               check("pop_instr", if_instr, e.instr);
            end
         end
      end
   end

   task automatic do_reset(input bit ready);
      rst_n = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      if_ready = ready;
      gnt_en = 1'b1;
      lat = 1;
      exp_q.delete();
      pop_cycles.delete();
      repeat (2) @(posedge clk);
      #1;
      check("reset_req", imem_req, 0);
      check("reset_addr", imem_addr, 32'h100);
      check("reset_valid", if_valid, 0);
      check("reset_pc", if_pc, 0);
      check("reset_instr", if_instr, 0);
      pop_count = 0;
      gnt_count = 0;
      @(posedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_gnts(input int n, input string name);
      int k = 0;
      while (gnt_count < n && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_gnt_timeout"}, gnt_count >= n, 1);
   endtask

   task automatic wait_pops(input int n, input string name);
      int k = 0;
      while (pop_count < n && k < 200) begin
         @(posedge clk);
         #3;
         k++;
      end
      check({name, "_pop_timeout"}, pop_count >= n, 1);
   endtask

   task automatic wait_req(input logic [31:0] addr, input string name);
      int k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!imem_req && k < 50);
      check({name, "_req_seen"}, imem_req, 1);
      check({name, "_req_addr"}, imem_addr, addr);
   endtask

   initial begin : stimulus
      int pc0;

      // Zero-wait memory, decode always ready: one instruction per two cycles.
      do_reset(1'b1);
      for (int i = 0; i < 8; i++) expect_pc(32'h100 + 32'(4 * i));
      #2;
      check("t1_req_before_edge", imem_req, 0);
      @(negedge clk);
      #1;
      check("t1_first_req", imem_req, 1);
      check("t1_first_addr", imem_addr, 32'h100);
      wait_pops(3, "t1");
      check("t1_gap01", pop_cycles[1] - pop_cycles[0], 2);
      check("t1_gap12", pop_cycles[2] - pop_cycles[1], 2);

      // Decode stalled: the queue fills to 4 and fetch stops, then drains at one per cycle.
      do_reset(1'b0);
      repeat (30) @(posedge clk);
      #1;
      check("t2_grants_when_full", gnt_count, 4);
      check("t2_req_idle", imem_req, 0);
      check("t2_valid", if_valid, 1);
      check("t2_head_pc", if_pc, 32'h100);
      for (int i = 0; i < 8; i++) expect_pc(32'h100 + 32'(4 * i));
      if_ready = 1'b1;
      wait_pops(5, "t2");
      check("t2_drain_gap1", pop_cycles[1] - pop_cycles[0], 1);
      check("t2_drain_gap2", pop_cycles[2] - pop_cycles[1], 1);
      check("t2_drain_gap3", pop_cycles[3] - pop_cycles[2], 1);
      check("t2_resumed", gnt_count >= 5, 1);

      // Slow memory, redirect mid-WAIT: the stale word never reaches decode.
      do_reset(1'b1);
      lat = 5;
      wait_gnts(1, "t3");
      @(posedge clk);
      redirect = 1'b1;
      redirect_pc = 32'h203;
      @(posedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) expect_pc(32'h200 + 32'(4 * i));
      #2;
      check("t3_discard_req", imem_req, 0);
      check("t3_discard_valid", if_valid, 0);
      wait_req(32'h200, "t3");
      wait_pops(2, "t3");

      // Redirect together with rvalid in WAIT and a decode pop: flush, no pop, IDLE then REQ.
      do_reset(1'b0);
      wait_gnts(2, "t4");
      @(posedge clk);
      pc0 = pop_count;
      redirect = 1'b1;
      redirect_pc = 32'h40;
      if_ready = 1'b1;
      @(posedge clk);
      redirect = 1'b0;
      #2;
      check("t4_flushed", if_valid, 0);
      check("t4_idle", imem_req, 0);
      check("t4_no_pop", pop_count, pc0);
      check("t4_hold_pc", if_pc, 32'h100);
      for (int i = 0; i < 4; i++) expect_pc(32'h40 + 32'(4 * i));
      @(negedge clk);
      #1;
      check("t4_req", imem_req, 1);
      check("t4_addr", imem_addr, 32'h40);
      wait_pops(2, "t4");

      // Fetch PC wrap from 0xFFFFFFFC, with the redirect low bits forced to zero.
      do_reset(1'b1);
      gnt_en = 1'b0;
      @(negedge clk);
      #1;
      check("t5_req", imem_req, 1);
      @(posedge clk);
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      @(posedge clk);
      redirect = 1'b0;
      #1;
      check("t5_req_held", imem_req, 1);
      check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      expect_pc(32'hFFFF_FFFC);
      expect_pc(32'h0000_0000);
      expect_pc(32'h0000_0004);
      gnt_en = 1'b1;
      wait_gnts(1, "t5");
      @(negedge clk);
      #1;
      check("t5_addr_wrapped", imem_addr, 32'h0);
      wait_pops(2, "t5");

      // Half-cycle reset pulse in WAIT: outputs clear at once, fetch restarts at RESET_PC.
      do_reset(1'b0);
      wait_gnts(2, "t6");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_async_req", imem_req, 0);
      check("t6_async_addr", imem_addr, 32'h100);
      check("t6_async_valid", if_valid, 0);
      check("t6_async_pc", if_pc, 0);
      check("t6_async_instr", if_instr, 0);
      #3;
      rst_n = 1'b1;
      expect_pc(32'h100);
      expect_pc(32'h104);
      expect_pc(32'h108);
      if_ready = 1'b1;
      wait_req(32'h100, "t6");
      wait_pops(2, "t6");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
